// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: releases the PLL, qualifies LOCKED, then releases the derived clock domains.
// Optional macro PLL_LOCK_SEQ_RELOCK_CNT_EN enables the saturating RELOCK_CNT counter (tied to 0 otherwise).
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 FORCE_RELOCK,
    input  logic                 PLL_LOCKED,
    output logic                 PLL_RST,
    output logic                 PLL_PWRDWN,
    output logic                 CLK_READY,
    output logic                 DOMAIN_RESET,
    output logic                 FAULT,
    output logic [2:0]           STATE,
    output logic [CNT_WIDTH-1:0] RELOCK_CNT
);
    // state     | meaning
    // IDLE      | PLL powered down and held in reset
    // RESET_PLL | PLL powered, reset pulse of RST_CYCLES
    // WAIT_LOCK | reset released, waiting for LOCKED (timeout -> retry)
    // STABLE    | LOCKED seen, qualifying for STABLE_CYCLES
    // RUN       | clocks qualified, derived domains released
    // FAULT     | retries exhausted, sticky until ENABLE=0
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESET_PLL = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_STABLE    = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] T_RST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);

    logic          locked_meta, locked_s;
    logic [2:0]    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [RW-1:0] retry, retry_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= PLL_LOCKED;
            locked_s    <= locked_meta;
        end
    end

    // One shared down-counter, reloaded on every state entry that needs timing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_nxt = retry;
        if (!ENABLE) begin
            state_nxt = ST_IDLE;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RESET_PLL;
                    timer_nxt = T_RST;
                end
                ST_RESET_PLL: begin
                    if (timer == '0) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = T_LOCK;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABLE;
                        timer_nxt = T_STABLE;
                    end else if (timer == '0) begin
                        retry_nxt = retry + 1'b1;
                        if (retry == RW'(MAX_RETRY - 1)) begin
                            state_nxt = ST_FAULT;
                        end else begin
                            state_nxt = ST_RESET_PLL;
                            timer_nxt = T_RST;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = T_LOCK;
                    end else if (timer == '0) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s || FORCE_RELOCK) begin
                        state_nxt = ST_RESET_PLL;
                        timer_nxt = T_RST;
                    end
                end
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            timer        <= '0;
            retry        <= '0;
            PLL_RST      <= 1'b1;
            PLL_PWRDWN   <= 1'b1;
            CLK_READY    <= 1'b0;
            DOMAIN_RESET <= 1'b1;
            FAULT        <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            retry        <= retry_nxt;
            PLL_RST      <= !((state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE) ||
                              (state_nxt == ST_RUN));
            PLL_PWRDWN   <= (state_nxt == ST_IDLE);
            CLK_READY    <= (state_nxt == ST_RUN);
            DOMAIN_RESET <= (state_nxt != ST_RUN);
            FAULT        <= (state_nxt == ST_FAULT);
        end
    end

    assign STATE = state;

`ifdef PLL_LOCK_SEQ_RELOCK_CNT_EN
    logic                 relock_evt;
    logic [CNT_WIDTH-1:0] relock_cnt;

    assign relock_evt = ENABLE && (state == ST_RUN) && (!locked_s || FORCE_RELOCK);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            relock_cnt <= '0;
        end else if (relock_evt && (relock_cnt != '1)) begin
            relock_cnt <= relock_cnt + 1'b1;
        end
    end

    assign RELOCK_CNT = relock_cnt;
`else
    assign RELOCK_CNT = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed scoreboard bench for pll_lock_sequencer; expected values are queued as stimulus is applied.
// Relock-count expectations follow PLL_LOCK_SEQ_RELOCK_CNT_EN (counter model when defined, 0 otherwise).
module tb_pll_lock_sequencer;
    localparam int RST_CYCLES    = 8;
    localparam int LOCK_TIMEOUT  = 4096;
    localparam int STABLE_CYCLES = 256;
    localparam int MAX_RETRY     = 3;
    localparam int CNT_WIDTH     = 2;

    logic                 clk = 1'b0;
    logic                 rst, enable, force_relock, pll_locked;
    logic                 pll_rst, pll_pwrdwn, clk_ready, domain_reset, fault;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] relock_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          rc_model = 0;
    int          n;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .ENABLE      (enable),
        .FORCE_RELOCK(force_relock),
        .PLL_LOCKED  (pll_locked),
        .PLL_RST     (pll_rst),
        .PLL_PWRDWN  (pll_pwrdwn),
        .CLK_READY   (clk_ready),
        .DOMAIN_RESET(domain_reset),
        .FAULT       (fault),
        .STATE       (state),
        .RELOCK_CNT  (relock_cnt)
    );

    function automatic logic [7:0] outs();
        return {pll_rst, pll_pwrdwn, clk_ready, domain_reset, fault, state};
    endfunction

    function automatic logic [31:0] exp_rc();
`ifdef PLL_LOCK_SEQ_RELOCK_CNT_EN
        return rc_model;
`else
        return 32'd0;
`endif
    endfunction

    task automatic relock_event();
        if (rc_model < (1 << CNT_WIDTH) - 1) rc_model++;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (state !== s && cnt <= limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic count_in_state(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (state === s && cnt <= limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic relock_to_run(input string tag);
        int k;
        pll_locked = 1'b1;
        push(tag, RST_CYCLES + 1 + STABLE_CYCLES);
        wait_state(3'd4, 1000, k);
        check(k);
    endtask

    task automatic force_pulse();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; force_relock = 1'b0; pll_locked = 1'b0;
        repeat (3) tick();
        push("reset_outs", 8'hD0);            check(outs());
        push("reset_rc", 0);                   check(relock_cnt);

        // Initial bring-up
        rst = 1'b0;
        tick();
        enable = 1'b1;
        push("idle_to_reset_pll", 1);          wait_state(3'd1, 5, n); check(n);
        push("rst_pulse_len", RST_CYCLES);     count_in_state(3'd1, 50, n); check(n);
        push("wait_lock_outs", 8'h12);         check(outs());
        repeat (20) tick();
        pll_locked = 1'b1;
        push("lock_to_ready", 2 + 1 + STABLE_CYCLES);
        wait_state(3'd4, 400, n);              check(n);
        push("run_outs", 8'h24);               check(outs());
        push("rc_initial", exp_rc());          check(relock_cnt);

        // Lock loss in RUN
        pll_locked = 1'b0;
        repeat (2) tick();
        push("ready_held_2cyc", 1);            check(clk_ready);
        tick();
        relock_event();
        push("lockloss_outs", 8'h91);          check(outs());
        push("rc_after_loss", exp_rc());       check(relock_cnt);
        relock_to_run("relock_run_1");

        // Lock loss and FORCE_RELOCK reaching the FSM together
        pll_locked = 1'b0;
        repeat (2) tick();
        force_pulse();
        relock_event();
        push("simul_state", 1);                check(state);
        push("rc_simultaneous", exp_rc());     check(relock_cnt);
        relock_to_run("relock_run_2");

        // Two forced relocks: counter reaches and holds all-ones
        for (int i = 0; i < 2; i++) begin
            force_pulse();
            relock_event();
            push("rc_forced", exp_rc());       check(relock_cnt);
            relock_to_run("relock_run_forced");
        end

        // Lock glitch at STABLE count 100
        force_pulse();
        relock_event();
        push("to_stable", RST_CYCLES + 1);     wait_state(3'd3, 50, n); check(n);
        repeat (100) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        push("glitch_to_wait", 1);             wait_state(3'd2, 10, n); check(n);
        push("glitch_rerun", 2 + STABLE_CYCLES); wait_state(3'd4, 600, n); check(n);
        push("rc_saturated", exp_rc());        check(relock_cnt);

        // Asynchronous reset while in STABLE
        force_pulse();
        push("to_stable_2", RST_CYCLES + 1);   wait_state(3'd3, 50, n); check(n);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        push("async_reset_outs", 8'hD0);       check(outs());
        push("async_reset_rc", 0);             check(relock_cnt);
        rc_model = 0;
        tick();
        rst = 1'b0;
        pll_locked = 1'b0;

        // Lock never arrives: three timeouts then FAULT
        push("fault_first_wait", 1 + RST_CYCLES); wait_state(3'd2, 50, n); check(n);
        force_pulse();
        push("force_ignored", 2);              check(state);
        for (int a = 0; a < MAX_RETRY; a++) begin
            push("timeout_window", (a == 0) ? LOCK_TIMEOUT - 1 : LOCK_TIMEOUT);
            count_in_state(3'd2, LOCK_TIMEOUT + 10, n); check(n);
            if (a < MAX_RETRY - 1) begin
                push("retry_rst_pulse", RST_CYCLES);
                count_in_state(3'd1, 50, n);   check(n);
            end
        end
        push("fault_outs", 8'h9D);             check(outs());
        repeat (5) tick();
        push("fault_sticky", 5);               check(state);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        push("disable_outs", 8'hD0);           check(outs());
        tick();
        push("reenable_state", 1);             check(state);
        push("reenable_rst_pulse", RST_CYCLES); count_in_state(3'd1, 50, n); check(n);
        push("reenable_window", LOCK_TIMEOUT); count_in_state(3'd2, LOCK_TIMEOUT + 10, n); check(n);
        push("retry_cleared", 1);              check(state);
        push("rc_final", exp_rc());            check(relock_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the board clocking PLL: holds it in reset/power-down, releases it, qualifies LOCKED for a fixed stable window, and only then deasserts the reset of the PLL-derived clock domains (CLK200/CLK400 logic). It runs on the free-running PLL input clock, upstream of the PLL. It re-locks automatically on loss of lock or on request, retries on lock timeout, and flags a sticky fault after repeated failures.

## Interface
Parameters:
- RST_CYCLES, 8: cycles PLL_RST is held high per reset attempt (>=1)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry
- STABLE_CYCLES, 256: consecutive synced-lock cycles required before RUN
- MAX_RETRY, 3: failed lock attempts before FAULT (>=1)
- CNT_WIDTH, 8: width of RELOCK_CNT

Ports:
- CLK  in  1  free-running reference clock (PLL input clock)
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  level; 0 = power down PLL and hold everything idle
- FORCE_RELOCK  in  1  single-cycle pulse; re-run PLL reset sequence from RUN
- PLL_LOCKED  in  1  PLL LOCKED, asynchronous to CLK
- PLL_RST  out  1  to PLL RST
- PLL_PWRDWN  out  1  to PLL PWRDWN
- CLK_READY  out  1  PLL clocks qualified
- DOMAIN_RESET  out  1  reset for PLL-derived domains (active high)
- FAULT  out  1  sticky lock failure
- STATE  out  3  current state encoding
- RELOCK_CNT  out  CNT_WIDTH  saturating count of re-locks from RUN

## Operation
- PLL_LOCKED passes through a 2-FF synchronizer -> LOCKED_S; all decisions use LOCKED_S.
- States (STATE encoding): IDLE=0, RESET_PLL=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- IDLE: PLL_PWRDWN=1, PLL_RST=1. ENABLE=1 -> RESET_PLL.
- RESET_PLL: PLL_RST=1 for exactly RST_CYCLES cycles -> WAIT_LOCK (timeout timer cleared).
- WAIT_LOCK: LOCKED_S=1 -> STABLE (stable counter cleared). Timer reaches LOCK_TIMEOUT -> retry count +1; if new count == MAX_RETRY -> FAULT, else RESET_PLL.
- STABLE: LOCKED_S=0 -> WAIT_LOCK (timer cleared, no retry increment). LOCKED_S high for STABLE_CYCLES consecutive cycles -> RUN; retry count cleared.
- RUN: CLK_READY=1, DOMAIN_RESET=0. LOCKED_S=0 or FORCE_RELOCK=1 -> RESET_PLL, RELOCK_CNT +1 (saturates at all-ones; simultaneous causes count once).
- FAULT: FAULT=1, PLL_RST=1, PLL_PWRDWN=0; exits only via ENABLE=0 or RESET.
- CLK_READY=1 and DOMAIN_RESET=0 only in RUN; PLL_RST=1 in every state except WAIT_LOCK, STABLE, RUN.
- Priority: RESET > ENABLE=0 (any state -> IDLE, clears FAULT and retry count; RELOCK_CNT kept) > state transitions. FORCE_RELOCK outside RUN is ignored.

## Timing
- All outputs registered, reflecting state on the same edge as the transition.
- Reset values: PLL_RST=1, PLL_PWRDWN=1, CLK_READY=0, DOMAIN_RESET=1, FAULT=0, STATE=0, RELOCK_CNT=0.
- PLL_LOCKED to LOCKED_S: 2 cycles.
- Lock loss in RUN: PLL_LOCKED falls at edge N -> CLK_READY=0, DOMAIN_RESET=1, PLL_RST=1 at edge N+3.
- Minimum WAIT_LOCK entry to CLK_READY: 1 (WAIT_LOCK->STABLE) + STABLE_CYCLES cycles after LOCKED_S rises.
- Mid-operation RESET asserts outputs to reset values asynchronously.

## Configuration
- PLL_LOCK_SEQ_RELOCK_CNT_EN defined: RELOCK_CNT counter implemented as above.
- Not defined: counter omitted, RELOCK_CNT tied to 0; all other behaviour unchanged.

## Test plan
- Defaults, ENABLE=1 after RESET, PLL_LOCKED rises 20 cycles after PLL_RST falls -> PLL_RST high exactly 8 cycles, CLK_READY=1 exactly 256+1 cycles after LOCKED_S rises, STATE=4.
- PLL_LOCKED never rises -> three 4096-cycle WAIT_LOCK windows separated by 8-cycle PLL_RST pulses, then FAULT=1, STATE=5; ENABLE low one cycle -> STATE=0, FAULT=0, PLL_PWRDWN=1.
- LOCKED glitches low for 2 cycles at STABLE count 100 -> return to WAIT_LOCK, count restarts; CLK_READY delayed accordingly, no retry consumed.
- In RUN, drop PLL_LOCKED -> 3 cycles later CLK_READY=0, DOMAIN_RESET=1, RELOCK_CNT=1; re-lock returns to RUN.
- FORCE_RELOCK and lock loss same cycle in RUN -> RELOCK_CNT +1 only; with CNT_WIDTH=2, four relocks -> RELOCK_CNT stays 3.
- RESET asserted in STABLE -> all outputs at reset values immediately; without PLL_LOCK_SEQ_RELOCK_CNT_EN, RELOCK_CNT=0 throughout.
